// File: rtl/col_delta_decoder_pkg.sv
// Shared constants, FSM encoding and helpers for the column-delta decoder.
package col_delta_decoder_pkg;

  localparam int unsigned CODE_W = 16;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned COL_W  = 32;

  localparam logic [14:0] ESC_CODE = 15'h7FFF;
  localparam logic [15:0] END_CODE = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELTA  = 3'd1,
    ST_ESC_HI = 3'd2,
    ST_ESC_LO = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/std_fifo.sv
// Generic synchronous FIFO; LATENCY 0 is fall-through (head visible while non-empty).
module std_fifo
  import col_delta_decoder_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LATENCY = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_data,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [log2(DEPTH):0]      o_count
);

  localparam int unsigned AW = log2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_count   = r_cnt;
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  generate
    if (LATENCY == 0) begin : g_fwft
      assign o_data = r_mem[r_rd];
    end else begin : g_reg
      logic [WIDTH-1:0] r_q;
      always_ff @(posedge clk) r_q <= r_mem[r_rd];
      assign o_data = r_q;
    end
  endgenerate

endmodule

// File: rtl/col_delta_decoder.sv
// Expands packed 16-bit delta codes into absolute 32-bit column indices, one per cycle.
module col_delta_decoder
  import col_delta_decoder_pkg::*;
#(
  parameter int unsigned IN_FIFO_DEPTH = 16,
  parameter int unsigned AF_SLACK      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_push,
  output logic              word_almost_full,
  input  logic              almost_full,
  output logic [COL_W-1:0]  col,
  output logic              push_col,
  output logic              row_end,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned CW = log2(IN_FIFO_DEPTH) + 1;

  state_t             r_state;
  logic [1:0]         r_idx;
  logic [COL_W-1:0]   r_cur_col;
  logic [CODE_W-1:0]  r_hi;
  logic               r_esc_re;
  logic [COL_W-1:0]   r_col;
  logic               r_push;
  logic               r_re;
  logic               r_done;
  logic               r_ovf;

  logic [WORD_W-1:0]  w_head;
  logic               w_empty;
  logic               w_full;
  logic [CW-1:0]      w_count;
  logic               w_adv;
  logic               w_pop;
  logic               w_drop;
  logic [CODE_W-1:0]  w_code;
  logic               w_is_end;
  logic               w_is_esc;
  logic               w_emit;
  logic [COL_W-1:0]   w_emit_val;
  logic               w_emit_re;

  std_fifo #(
    .WIDTH   (WORD_W),
    .DEPTH   (IN_FIFO_DEPTH),
    .LATENCY (0)
  ) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (word_push),
    .i_data  (word_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // Consumption stalls on empty input or downstream backpressure; DONE only drains.
  assign w_adv    = !w_empty && !almost_full && (r_state != ST_DONE);
  assign w_pop    = (r_state == ST_DONE) ? !w_empty : (w_adv && (r_idx == 2'd3));
  assign w_drop   = word_push && w_full && !w_pop;
  assign w_code   = w_head[{r_idx, 4'b0000} +: CODE_W];
  assign w_is_end = (w_code == END_CODE);
  assign w_is_esc = (w_code[14:0] == ESC_CODE) && !w_is_end;

  assign w_emit = w_adv && (((r_state == ST_IDLE || r_state == ST_DELTA) && !w_is_end && !w_is_esc)
                            || (r_state == ST_ESC_LO));
  assign w_emit_val = (r_state == ST_ESC_LO) ? {r_hi, w_code}
                                             : r_cur_col + COL_W'(w_code[14:0]);
  assign w_emit_re  = (r_state == ST_ESC_LO) ? r_esc_re : w_code[15];

  assign word_almost_full = (CW'(IN_FIFO_DEPTH) - w_count) <= CW'(AF_SLACK);
  assign col      = r_col;
  assign push_col = r_push;
  assign row_end  = r_re;
  assign done     = r_done;
  assign overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= 2'd0;
      r_cur_col <= '0;
      r_hi      <= '0;
      r_esc_re  <= 1'b0;
      r_col     <= '0;
      r_push    <= 1'b0;
      r_re      <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_push <= w_emit;
      if (w_drop) r_ovf <= 1'b1;
      if (w_adv)  r_idx <= r_idx + 2'd1;
      // A row-end column restarts the running base at zero for the next row.
      if (w_emit) begin
        r_col     <= w_emit_val;
        r_re      <= w_emit_re;
        r_cur_col <= w_emit_re ? '0 : w_emit_val;
      end
      case (r_state)
        ST_IDLE, ST_DELTA: begin
          if (w_adv) begin
            if (w_is_end) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (w_is_esc) begin
              r_esc_re <= w_code[15];
              r_state  <= ST_ESC_HI;
            end else begin
              r_state <= ST_DELTA;
            end
          end
        end
        ST_ESC_HI: begin
          if (w_adv) begin
            if (w_is_end) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_hi    <= w_code;
              r_state <= ST_ESC_LO;
            end
          end
        end
        ST_ESC_LO: begin
          if (w_adv) r_state <= ST_DELTA;
        end
        ST_DONE: r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_col_delta_decoder.sv
// Directed bench for col_delta_decoder: vector table plus multi-cycle corner sequences.
module tb_col_delta_decoder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned SLACK = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] word_in = '0;
  logic        word_push = 1'b0;
  logic        almost_full = 1'b0;
  logic        word_almost_full;
  logic [31:0] col;
  logic        push_col;
  logic        row_end;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  col_delta_decoder #(.IN_FIFO_DEPTH(DEPTH), .AF_SLACK(SLACK)) dut (
    .clk              (clk),
    .rst              (rst),
    .word_in          (word_in),
    .word_push        (word_push),
    .word_almost_full (word_almost_full),
    .almost_full      (almost_full),
    .col              (col),
    .push_col         (push_col),
    .row_end          (row_end),
    .done             (done),
    .overflow         (overflow)
  );

  typedef struct packed {
    logic [63:0]      word;
    logic [3:0][31:0] c;
    logic [3:0]       re;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q_col[$];
  logic        q_re[$];
  vec_t        vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    word_push = 1'b0;
    almost_full = 1'b0;
    step();
    rst = 1'b1;
  endtask

  function automatic vec_t mkvec(input logic [63:0] w, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d, input logic [3:0] re);
    vec_t v;
    v.word = w;
    v.c[0] = a; v.c[1] = b; v.c[2] = c; v.c[3] = d;
    v.re   = re;
    return v;
  endfunction

  // Push one word and check exact output timing: columns on the 2nd..5th following cycles.
  task automatic run_vec(input vec_t v);
    word_in = v.word;
    word_push = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) word_push = 1'b0;
      chk("vec push_col", 32'(push_col), 32'((k >= 2) && (k <= 5)));
      if ((k >= 2) && (k <= 5)) begin
        chk("vec col", col, v.c[k-2]);
        chk("vec row_end", 32'(row_end), 32'(v.re[k-2]));
      end
    end
  endtask

  // Gather up to n columns within a cycle budget; a short count is reported by the caller.
  task automatic collect(input int n, input int budget);
    q_col.delete();
    q_re.delete();
    for (int i = 0; i < budget; i++) begin
      step();
      if (push_col) begin
        q_col.push_back(col);
        q_re.push_back(row_end);
      end
      if (q_col.size() >= n) break;
    end
    chk("collect count", 32'(q_col.size()), 32'(n));
  endtask

  task automatic push_word(input logic [63:0] w);
    word_in = w;
    word_push = 1'b1;
    step();
    word_push = 1'b0;
  endtask

  initial begin
    int npush;
    logic [31:0] exp_c[6];
    logic        exp_r[6];

    vecs[0] = mkvec(64'h8003_0002_0005_0001, 32'd1, 32'd6, 32'd8, 32'd11, 4'b1000);
    vecs[1] = mkvec(64'h8000_7FFE_8001_0000, 32'd0, 32'd1, 32'h7FFE, 32'h7FFE, 4'b1010);
    vecs[2] = mkvec(64'h8000_0000_0000_0004, 32'd4, 32'd4, 32'd4, 32'd4, 4'b1000);
    vecs[3] = mkvec(64'h8000_8000_8000_8000, 32'd0, 32'd0, 32'd0, 32'd0, 4'b1111);
    vecs[4] = mkvec(64'h0001_0001_0001_0001, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0000);

    do_reset();
    chk("reset push_col", 32'(push_col), 32'd0);
    chk("reset col", col, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset word_af", 32'(word_almost_full), 32'd0);

    // Back-to-back table vectors; each follows a row end or reset, so starts from 0.
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Escape straddling two words, then END.
    do_reset();
    word_in = {16'h7FFF, 16'h8001, 16'h0001, 16'h0001};
    word_push = 1'b1;
    step();
    word_in = {16'hFFFF, 16'h0001, 16'h3456, 16'h0012};
    collect(5, 30);
    word_push = 1'b0;
    exp_c[0] = 32'd1; exp_c[1] = 32'd2; exp_c[2] = 32'd3; exp_c[3] = 32'h0012_3456; exp_c[4] = 32'h0012_3457;
    exp_r[0] = 1'b0;  exp_r[1] = 1'b0;  exp_r[2] = 1'b1;  exp_r[3] = 1'b0;          exp_r[4] = 1'b0;
    for (int i = 0; i < 5 && i < q_col.size(); i++) begin
      chk("esc col", q_col[i], exp_c[i]);
      chk("esc row_end", 32'(q_re[i]), 32'(exp_r[i]));
    end
    chk("done before END", 32'(done), 32'd0);
    step();
    chk("done after END", 32'(done), 32'd1);
    push_word(64'h0001_0001_0001_0001);
    npush = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (push_col) npush++;
    end
    chk("no cols after done", 32'(npush), 32'd0);
    chk("done sticky", 32'(done), 32'd1);

    // Wrap past 2^32 through an escape with an all-ones low half.
    do_reset();
    word_in = {16'h7FFE, 16'hFFFF, 16'hFFFE, 16'h7FFF};
    word_push = 1'b1;
    step();
    word_in = {16'h8000, 16'h0003, 16'h0003, 16'h7FFE};
    collect(6, 30);
    word_push = 1'b0;
    exp_c[0] = 32'hFFFE_FFFF; exp_c[1] = 32'hFFFF_7FFD; exp_c[2] = 32'hFFFF_FFFB;
    exp_c[3] = 32'hFFFF_FFFE; exp_c[4] = 32'h0000_0001; exp_c[5] = 32'h0000_0001;
    for (int i = 0; i < 6 && i < q_col.size(); i++) begin
      chk("wrap col", q_col[i], exp_c[i]);
      chk("wrap row_end", 32'(q_re[i]), 32'(i == 5));
    end
    chk("wrap overflow", 32'(overflow), 32'd0);
    chk("wrap done", 32'(done), 32'd0);

    // ESCAPE immediately followed by END: END wins, nothing emitted.
    do_reset();
    push_word({16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF});
    npush = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (push_col) npush++;
    end
    chk("esc-end no cols", 32'(npush), 32'd0);
    chk("esc-end done", 32'(done), 32'd1);

    // Backpressure for 5 cycles after the second column.
    do_reset();
    push_word({16'h8004, 16'h0003, 16'h0002, 16'h0001});
    chk("bp idle", 32'(push_col), 32'd0);
    step();
    chk("bp col0", col, 32'd1);
    step();
    chk("bp col1", col, 32'd3);
    almost_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp stalled", 32'(push_col), 32'd0);
    end
    almost_full = 1'b0;
    step();
    chk("bp resume push", 32'(push_col), 32'd1);
    chk("bp col2", col, 32'd6);
    step();
    chk("bp col3", col, 32'd10);
    chk("bp row_end", 32'(row_end), 32'd1);

    // Fill past capacity while the cache holds off consumption.
    do_reset();
    almost_full = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      word_in = {16'h8000 | 16'(i), 16'h0000, 16'h0000, 16'(i)};
      word_push = 1'b1;
      step();
      chk("fill word_af", 32'(word_almost_full), 32'(i >= 10));
      chk("fill overflow", 32'(overflow), 32'(i == 17));
    end
    word_push = 1'b0;
    almost_full = 1'b0;
    collect(64, 200);
    for (int i = 0; i < 64 && i < q_col.size(); i++) begin
      chk("drain col", q_col[i], ((i % 4) == 3) ? 32'(2 * (i / 4 + 1)) : 32'(i / 4 + 1));
      chk("drain row_end", 32'(q_re[i]), 32'((i % 4) == 3));
    end
    npush = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (push_col) npush++;
    end
    chk("dropped word absent", 32'(npush), 32'd0);
    do_reset();
    chk("overflow cleared", 32'(overflow), 32'd0);

    // Reset while in ESC_HI discards partial state and the queued word.
    do_reset();
    word_in = {16'h7FFF, 16'h8003, 16'h0002, 16'h0001};
    word_push = 1'b1;
    step();
    word_in = {16'h0000, 16'h0000, 16'h0000, 16'h0009};
    step();
    word_push = 1'b0;
    chk("pre-rst col0", col, 32'd1);
    step();
    step();
    chk("pre-rst col2", col, 32'd6);
    chk("pre-rst row_end", 32'(row_end), 32'd1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rst push_col", 32'(push_col), 32'd0);
    chk("rst col", col, 32'd0);
    chk("rst row_end", 32'(row_end), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst word_af", 32'(word_almost_full), 32'd0);
    npush = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (push_col) npush++;
    end
    chk("rst fifo flushed", 32'(npush), 32'd0);
    run_vec(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
